uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable bit period, data width and parity mode, false-start rejection, framing/parity/overrun error reporting.
- Received words go into an internal show-ahead FIFO with a valid/ready read port.
- Sits between the board RX pin and the echo/command logic.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (>=4)
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0=none, 1=odd, 2=even
FIFO_DEPTH, 4, entries in the receive FIFO (power of 2, >=2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rxd  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  FIFO head word, valid when rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts head; pop when rx_valid & rx_ready
rx_count  output  clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_err  output  1  one-cycle pulse: stop bit sampled 0
parity_err  output  1  one-cycle pulse: parity mismatch
overrun  output  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
- Reset (async, rst=1):
  - State IDLE; sync flops =1; FIFO empty; counters 0.
  - rx_valid=0, rx_count=0, rx_data=0, all error pulses 0.
- rxd passes a 2-flop synchroniser (reset 1). All "samples" below use the synchronised value rxs.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; error path STOP -> BREAK -> IDLE.
- IDLE: on rxs=0, load bit counter and enter START.
- START: after CLKS_PER_BIT/2 cycles (integer division), sample.
  - rxs=1: false start; back to IDLE, nothing written, no error.
  - Else enter DATA.
- DATA: sample every CLKS_PER_BIT cycles, mid-bit.
  - Shift in LSB first, DATA_BITS samples.
  - Then PARITY if PARITY!=0, else STOP.
- PARITY: sample one bit CLKS_PER_BIT later.
  - Odd mode: XOR of data and parity bit must be 1.
  - Even mode: that XOR must be 0.
  - Mismatch is recorded.
- STOP: sample CLKS_PER_BIT later, then resolve in this priority:
  - rxs=0: frame_err pulses the next cycle; word discarded; go to BREAK. Any parity mismatch is not reported.
  - Parity mismatch: parity_err pulses the next cycle; word discarded; go to IDLE.
  - Otherwise push the word. If FIFO full and no pop in the same cycle, drop the word and pulse overrun. Go to IDLE.
- BREAK: wait for rxs=1, then IDLE. Line held low never produces repeated frames.
- Latency:
  - Word written on the cycle after the stop sample.
  - rx_valid rises the same cycle and rx_data shows the word (show-ahead).
- FIFO:
  - Push and pop in the same cycle when full: both occur, count unchanged, no overrun.
  - Push and pop when empty is impossible (pop needs valid).
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_count is exact at all times.
  - rx_ready while rx_valid=0 is ignored.
- rx_data is undefined-but-stable (previous head) when rx_valid=0. The bench must not check it.
- Reset mid-frame aborts the frame and empties the FIFO. After release, reception restarts only on a fresh falling edge.
- rxd glitch shorter than CLKS_PER_BIT/2 in IDLE is a false start.

Test Plan:
- Defaults, rst 1->0, rxd low 434 clks, high 434, low 7*434, then high -> rx_valid=1, rx_data=0x01, rx_count=1, no error pulses.
- Send 0x55, 0xA3, 0xFF, 0x00 back-to-back, rx_ready=0 -> rx_count=4; then rx_ready=1 pops them in order, rx_valid=0 after 4 pops. Fifth frame while full (before pops) -> overrun pulse, 0x55 still head.
- PARITY=2, DATA_BITS=7: send 0x41 with parity 0 -> accepted. Same word with parity 1 -> parity_err pulse, rx_count unchanged.
- Stop bit forced 0, then line held low 5000 clks -> exactly one frame_err pulse, no writes. Line high then new 0x3C frame -> accepted.
- rxd low pulse of 100 clks in IDLE -> no state change beyond START, no write, no error.
- rst asserted mid-DATA with 2 words queued -> rx_valid=0 and rx_count=0 immediately (async). Next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with a configurable bit period, data width and parity mode.
// The line is sampled at mid-bit. A start bit that is not still low at mid-bit
// is ignored as a false start. Frames with a bad stop bit or bad parity are
// reported and discarded. Good words go into a show-ahead FIFO with a
// valid/ready read port.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, BRK
    } state_t;

    state_t                 state, state_nxt;
    logic                   sync1, rxs;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bitcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   tick;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wptr, rptr;
    logic [AW:0]            count;
    logic                   push, pop, full, wr_en;

    assign tick = (cnt == '0);

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: walk the frame, rejecting false starts and waiting out a held-low line.
    // NOTE: assigning the default first keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rxs) state_nxt = START;
            START: if (tick) state_nxt = rxs ? IDLE : DATA;
            DATA:  if (tick && bitcnt == LAST_BIT) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (tick) state_nxt = STOP;
            STOP:  if (tick) state_nxt = rxs ? IDLE : BRK;
            BRK:   if (rxs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing, data shifting, parity tracking and the error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (state == IDLE) begin
                // Half a bit to reach the middle of the start bit.
                cnt     <= HALF_M1;
                bitcnt  <= '0;
                par_bad <= 1'b0;
            end else if (tick) begin
                cnt <= FULL_M1;
            end else begin
                cnt <= cnt - 1'b1;
            end

            if (tick) begin
                case (state)
                    DATA: begin
                        shreg  <= {rxs, shreg[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 1'b1;
                    end
                    PAR:  par_bad    <= (^shreg) ^ rxs ^ (PARITY == 1);
                    STOP: begin
                        frame_err  <= !rxs;
                        parity_err <= rxs & par_bad;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign push     = (state == STOP) && tick && rxs && !par_bad;
    assign rx_valid = (count != '0);
    assign pop      = rx_valid && rx_ready;
    assign full     = (count == DEPTH);
    assign wr_en    = push && (!full || pop);
    assign rx_data  = mem[rptr];
    assign rx_count = count;

    // Receive FIFO: write a good word, pop on handshake, flag a word lost to a full FIFO.
    // NOTE: the storage is reset so the head word reads as zero after reset; it is only a few words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default 8N1 instance at 434 clocks per bit and a
// 7-bit even-parity instance at 16 clocks per bit. Frames are modelled as
// whole words in a queue; error pulses are counted and compared to the model.
module tb_uart_rx_fifo;

    localparam int CPB_A = 434;
    localparam int CPB_B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, valid_b;
    logic [2:0] cnt_a, cnt_b;
    logic       ferr_a, perr_a, ovr_a, ferr_b, perr_b, ovr_b;

    uart_rx_fifo u_dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a), .rx_count(cnt_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b), .rx_count(cnt_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int seen_ferr[2] = '{0, 0};
    int seen_perr[2] = '{0, 0};
    int seen_ovr[2]  = '{0, 0};
    int exp_ferr[2]  = '{0, 0};
    int exp_perr[2]  = '{0, 0};
    int exp_ovr[2]   = '{0, 0};

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    // Count cycles on which each error pulse is high.
    always @(negedge clk) begin
        if (ferr_a) seen_ferr[0]++;
        if (perr_a) seen_perr[0]++;
        if (ovr_a)  seen_ovr[0]++;
        if (ferr_b) seen_ferr[1]++;
        if (perr_b) seen_perr[1]++;
        if (ovr_b)  seen_ovr[1]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rxd(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    function automatic logic [8:0] get_data(input bit sel);
        return sel ? {2'b00, data_b} : {1'b0, data_a};
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? valid_b : valid_a;
    endfunction

    function automatic logic [2:0] get_count(input bit sel);
        return sel ? cnt_b : cnt_a;
    endfunction

    function automatic int q_size(input bit sel);
        return sel ? q_b.size() : q_a.size();
    endfunction

    function automatic logic [8:0] q_head(input bit sel);
        return sel ? q_b[0] : q_a[0];
    endfunction

    // Serialise one frame: start, data LSB first, optional parity, stop.
    task automatic send_frame(input bit sel, input logic [8:0] data, input bit flip_par, input bit stop_val);
        int         nb  = sel ? 7 : 8;
        int         cpb = sel ? CPB_B : CPB_A;
        logic [8:0] d   = sel ? (data & 9'h07F) : (data & 9'h0FF);
        logic       p;
        set_rxd(sel, 1'b0);
        wait_clks(cpb);
        for (int i = 0; i < nb; i++) begin
            set_rxd(sel, d[i]);
            wait_clks(cpb);
        end
        if (sel) begin
            p = (^d) ^ flip_par;   // even parity: data XOR parity must be 0
            set_rxd(sel, p);
            wait_clks(cpb);
        end
        set_rxd(sel, stop_val);
        wait_clks(cpb);
    endtask

    // Reference outcome of one frame: frame error beats parity error beats write/overrun.
    task automatic model_frame(input bit sel, input logic [8:0] data, input bit flip_par, input bit stop_val);
        logic [8:0] d = sel ? (data & 9'h07F) : (data & 9'h0FF);
        if (!stop_val)               exp_ferr[sel]++;
        else if (sel && flip_par)    exp_perr[sel]++;
        else if (q_size(sel) == 4)   exp_ovr[sel]++;
        else if (sel)                q_b.push_back(d);
        else                         q_a.push_back(d);
    endtask

    task automatic check_state(input bit sel, input string tag);
        check({tag, ".count"}, 32'(get_count(sel)), 32'(q_size(sel)));
        check({tag, ".valid"}, 32'(get_valid(sel)), 32'(q_size(sel) != 0));
        if (q_size(sel) != 0) check({tag, ".head"}, 32'(get_data(sel)), 32'(q_head(sel)));
        check({tag, ".ferr"}, 32'(seen_ferr[sel]), 32'(exp_ferr[sel]));
        check({tag, ".perr"}, 32'(seen_perr[sel]), 32'(exp_perr[sel]));
        check({tag, ".ovr"},  32'(seen_ovr[sel]),  32'(exp_ovr[sel]));
    endtask

    // Pop the head word with a one-cycle ready, checking it against the model first.
    task automatic pop_one(input bit sel, input string tag);
        logic [8:0] e;
        check({tag, ".pop_valid"}, 32'(get_valid(sel)), 32'(1));
        if (q_size(sel) != 0) begin
            e = sel ? q_b.pop_front() : q_a.pop_front();
            check({tag, ".pop_data"}, 32'(get_data(sel)), 32'(e));
        end
        if (sel) ready_b = 1'b1;
        else     ready_a = 1'b1;
        wait_clks(1);
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    initial begin
        logic [8:0] words[4] = '{9'h055, 9'h0A3, 9'h0FF, 9'h000};
        logic [8:0] rd;
        bit         flip, stop;

        // Reset state.
        wait_clks(3);
        check("rst.valid", 32'({valid_a, valid_b}), 32'(0));
        check("rst.count", 32'({cnt_a, cnt_b}), 32'(0));
        check("rst.data",  32'({data_a, data_b}), 32'(0));
        check("rst.pulses", 32'({ferr_a, perr_a, ovr_a, ferr_b, perr_b, ovr_b}), 32'(0));
        rst = 1'b0;
        wait_clks(5);

        // First word 0x01.
        send_frame(0, 9'h001, 0, 1);
        model_frame(0, 9'h001, 0, 1);
        wait_clks(2);
        check_state(0, "t1");
        pop_one(0, "t1");
        check_state(0, "t1_after");

        // Four back-to-back words fill the FIFO, a fifth overruns.
        foreach (words[i]) begin
            send_frame(0, words[i], 0, 1);
            model_frame(0, words[i], 0, 1);
        end
        wait_clks(2);
        check_state(0, "t2_full");
        send_frame(0, 9'h099, 0, 1);
        model_frame(0, 9'h099, 0, 1);
        wait_clks(2);
        check_state(0, "t2_ovr");
        for (int i = 0; i < 4; i++) pop_one(0, "t2");
        check_state(0, "t2_empty");

        // Even parity, 7 data bits.
        send_frame(1, 9'h041, 0, 1);
        model_frame(1, 9'h041, 0, 1);
        wait_clks(2);
        check_state(1, "t3_good");
        send_frame(1, 9'h041, 1, 1);
        model_frame(1, 9'h041, 1, 1);
        wait_clks(2);
        check_state(1, "t3_bad");
        pop_one(1, "t3");

        // Random frames on the parity instance with random errors and pops.
        for (int n = 0; n < 40; n++) begin
            rd   = 9'($urandom_range(0, 127));
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(1, rd, flip, stop);
            if (!stop) begin
                wait_clks($urandom_range(20, 200));
                rxd_b = 1'b1;
                wait_clks(2 * CPB_B);
            end else begin
                wait_clks($urandom_range(0, 5));
            end
            model_frame(1, rd, flip, stop);
            check_state(1, "rnd");
            if ($urandom_range(0, 1) == 1 && q_size(1) != 0) pop_one(1, "rnd");
        end
        while (q_size(1) != 0) pop_one(1, "rnd_drain");
        check_state(1, "rnd_end");

        // Stop bit low, line held low: one frame error, then normal reception.
        send_frame(0, 9'h0C3, 0, 0);
        wait_clks(5000);
        rxd_a = 1'b1;
        wait_clks(CPB_A);
        model_frame(0, 9'h0C3, 0, 0);
        check_state(0, "t4_break");
        send_frame(0, 9'h03C, 0, 1);
        model_frame(0, 9'h03C, 0, 1);
        wait_clks(2);
        check_state(0, "t4_next");
        pop_one(0, "t4");

        // Short glitch in idle is a false start.
        rxd_a = 1'b0;
        wait_clks(100);
        rxd_a = 1'b1;
        wait_clks(400);
        check_state(0, "t5_glitch");

        // Reset mid-frame with two words queued.
        send_frame(0, 9'h011, 0, 1);
        model_frame(0, 9'h011, 0, 1);
        send_frame(0, 9'h022, 0, 1);
        model_frame(0, 9'h022, 0, 1);
        wait_clks(2);
        check_state(0, "t6_queued");
        rxd_a = 1'b0;
        wait_clks(CPB_A);
        rxd_a = 1'b1; wait_clks(CPB_A);
        rxd_a = 1'b0; wait_clks(CPB_A);
        rxd_a = 1'b1; wait_clks(100);
        #2 rst = 1'b1;
        #1;
        check("t6.rst_valid", 32'(valid_a), 32'(0));
        check("t6.rst_count", 32'(cnt_a), 32'(0));
        q_a.delete();
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2 * CPB_A);
        check_state(0, "t6_idle");
        send_frame(0, 9'h05A, 0, 1);
        model_frame(0, 9'h05A, 0, 1);
        wait_clks(2);
        check_state(0, "t6_new");
        pop_one(0, "t6");
        check_state(0, "t6_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
